// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device command path.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_NOACK   = 2'b10,
    ERR_RETRY   = 2'b11
  } err_e;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  // PS/2 uses odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_tx_shift.sv
// 11-bit host-to-device frame serializer (start, 8 data LSB first, parity, stop).
// Bit 0 of the frame register is the bit currently on the line.
module ps2_tx_shift
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_cmd,
  input  logic       i_adv,
  output logic       o_dat_oe,
  output logic       o_last
);

  logic [10:0] frame_q, frame_d;
  logic [3:0]  idx_q, idx_d;

  always_comb begin
    frame_d = frame_q;
    idx_d   = idx_q;
    if (i_load) begin
      frame_d = {1'b1, odd_parity(i_cmd), i_cmd, 1'b0};
      idx_d   = 4'd0;
    end else if (i_adv) begin
      // Shift in ones so an over-run leaves the line released.
      frame_d = {1'b1, frame_q[10:1]};
      idx_d   = idx_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_q <= '1;
      idx_q   <= 4'd0;
    end else begin
      frame_q <= frame_d;
      idx_q   <= idx_d;
    end
  end

  assign o_dat_oe = ~frame_q[0];
  // Next advance puts the stop bit on the line.
  assign o_last   = (idx_q == 4'd9);

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host-to-device command sequencer: inhibit, RTS, shift frame, line ACK,
// then wait for the 0xFA / 0xFE response with bounded resend and timeout.
module ps2_cmd_ctrl
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 2
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_edge_en,
  input  logic       i_ps2_dat,
  input  logic       i_byte_en,
  input  logic [7:0] i_byte,
  input  logic       i_cmd_valid,
  input  logic [7:0] i_cmd,
  output logic       o_cmd_ready,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_dat_oe,
  output logic       o_rx_hold,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [1:0] o_err_code
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  state_e             state_q, state_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [INH_W-1:0]   inh_q, inh_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  err_e               code_q, code_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               sh_load, sh_adv, sh_dat_oe, sh_last;

  ps2_tx_shift u_shift (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_load   (sh_load),
    .i_cmd    (cmd_q),
    .i_adv    (sh_adv),
    .o_dat_oe (sh_dat_oe),
    .o_last   (sh_last)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    inh_d   = inh_q;
    tmo_d   = tmo_q;
    retry_d = retry_q;
    code_d  = code_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    sh_load = 1'b0;
    sh_adv  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          cmd_d   = i_cmd;
          retry_d = '0;
          code_d  = ERR_NONE;
          inh_d   = '0;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          sh_load = 1'b1;
          state_d = ST_RTS;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      ST_RTS: begin
        // Counts cycles since RTS, so the value in SHIFT's first cycle is 1.
        tmo_d   = TMO_W'(1);
        state_d = ST_SHIFT;
      end
      ST_SHIFT, ST_ACK, ST_RESP: begin
        if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          code_d  = ERR_TIMEOUT;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (state_q == ST_SHIFT) begin
            if (i_edge_en) begin
              sh_adv = 1'b1;
              if (sh_last) state_d = ST_ACK;
            end
          end else if (state_q == ST_ACK) begin
            if (i_edge_en) begin
              if (!i_ps2_dat) begin
                state_d = ST_RESP;
              end else begin
                code_d  = ERR_NOACK;
                err_d   = 1'b1;
                state_d = ST_IDLE;
              end
            end
          end else if (i_byte_en) begin
            if (i_byte == PS2_ACK) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else if (i_byte == PS2_RESEND) begin
              if (retry_q < RTY_W'(MAX_RETRY)) begin
                retry_d = retry_q + 1'b1;
                inh_d   = '0;
                state_d = ST_INHIBIT;
              end else begin
                code_d  = ERR_RETRY;
                err_d   = 1'b1;
                state_d = ST_IDLE;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      inh_q   <= '0;
      tmo_q   <= '0;
      retry_q <= '0;
      code_q  <= ERR_NONE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      inh_q   <= inh_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
      code_q  <= code_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Line drives decode straight from registered state so reset releases them at once.
  assign o_cmd_ready  = (state_q == ST_IDLE);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_ps2_clk_oe = (state_q == ST_INHIBIT) || (state_q == ST_RTS);
  assign o_ps2_dat_oe = ((state_q == ST_RTS) || (state_q == ST_SHIFT) || (state_q == ST_ACK))
                        && sh_dat_oe;
  assign o_rx_hold    = (state_q == ST_INHIBIT) || (state_q == ST_RTS) ||
                        (state_q == ST_SHIFT)   || (state_q == ST_ACK);
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_err_code   = code_q;

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Bench for ps2_cmd_ctrl: a PS/2 device model drives edges, ACK and response bytes.
module tb_ps2_cmd_ctrl;
  import ps2_pkg::*;

  localparam int INH  = 16;
  localparam int TMO  = 200;
  localparam int MAXR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       edge_en = 1'b0;
  logic       ps2_dat = 1'b1;
  logic       byte_en = 1'b0;
  logic [7:0] byte_v = 8'h00;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic       cmd_ready, clk_oe, dat_oe, rx_hold, busy, done, err;
  logic [1:0] err_code;

  ps2_cmd_ctrl #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRY      (MAXR)
  ) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_edge_en    (edge_en),
    .i_ps2_dat    (ps2_dat),
    .i_byte_en    (byte_en),
    .i_byte       (byte_v),
    .i_cmd_valid  (cmd_valid),
    .i_cmd        (cmd),
    .o_cmd_ready  (cmd_ready),
    .o_ps2_clk_oe (clk_oe),
    .o_ps2_dat_oe (dat_oe),
    .o_rx_hold    (rx_hold),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_err_code   (err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, busy_at_done = 0;
  int err_cyc = 0, rts_cyc = 0;
  int last_code = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (busy) busy_at_done++;
    end
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
      last_code = int'(err_code);
    end
    if (clk_oe && dat_oe) rts_cyc = cyc;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_edge();
    edge_en = 1'b1;
    tick(1);
    edge_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_v  = b;
    byte_en = 1'b1;
    tick(1);
    byte_en = 1'b0;
  endtask

  task automatic start_cmd(input logic [7:0] c);
    tick(1);
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd = c;
    tick(1);
    cmd_valid = 1'b0;
    cmd = 8'($urandom);
    chk("busy_after_accept", 32'(busy), 1);
    chk("code_cleared_on_accept", 32'(err_code), 0);
  endtask

  // Measures the inhibit + RTS window; returns with the DUT in SHIFT.
  task automatic wait_frame_start(output bit ok);
    int n, hi, rts;
    n = 0;
    while (!clk_oe && n < 50) begin
      tick(1);
      n++;
    end
    hi = 0;
    rts = 0;
    while (clk_oe && hi < INH + 10) begin
      hi++;
      if (dat_oe) rts++;
      tick(1);
    end
    chk("inhibit_plus_rts_len", 32'(hi), 32'(INH + 1));
    chk("rts_cycles", 32'(rts), 1);
    chk("start_bit_held", 32'(dat_oe), 1);
    chk("rx_hold_in_shift", 32'(rx_hold), 1);
    ok = (hi == INH + 1);
  endtask

  // Expected line value of frame bit e (1..8 data LSB first, 9 parity, 10 stop).
  function automatic int ref_bit(input logic [7:0] c, input int e);
    int ones;
    ones = 0;
    for (int k = 0; k < 8; k++) ones += int'(c[k]);
    if (e <= 8) return int'(c[e-1]);
    if (e == 9) return (ones % 2 == 0) ? 1 : 0;
    return 1;
  endfunction

  task automatic send_frame(input logic [7:0] c, input bit nack, input bit noise);
    for (int e = 1; e <= 10; e++) begin
      tick(2);
      if (noise && e == 3) send_byte(PS2_ACK);
      pulse_edge();
      if (e == 1) chk("clk_released_in_shift", 32'(clk_oe), 0);
      chk($sformatf("frame_bit%0d_cmd%02h", e, c), 32'(!dat_oe), 32'(ref_bit(c, e)));
    end
    tick(2);
    ps2_dat = nack;
    pulse_edge();
    ps2_dat = 1'b1;
    chk("rx_hold_after_ack", 32'(rx_hold), 0);
    chk("busy_after_ack", 32'(busy), nack ? 0 : 1);
  endtask

  task automatic run_cmd(input logic [7:0] c, input bit nack, input int n_fe, input bit noise,
                         output int frames);
    bit ok;
    start_cmd(c);
    frames = 0;
    for (int f = 0; f < 6; f++) begin
      wait_frame_start(ok);
      if (!ok) break;
      frames++;
      send_frame(c, nack && f == 0, noise);
      if (nack && f == 0) break;
      tick(2);
      if (noise) send_byte(8'h55);
      tick(1);
      send_byte((f < n_fe) ? PS2_RESEND : PS2_ACK);
      if (!clk_oe) break;
    end
    tick(2);
  endtask

  // Outcome from the command's rules: nack ends the first frame; each 0xFE beyond MAX_RETRY fails.
  task automatic model(input bit nack, input int n_fe,
                       output int e_done, output int e_err, output int e_code, output int e_frames);
    if (nack) begin
      e_done = 0; e_err = 1; e_code = 2; e_frames = 1;
    end else if (n_fe > MAXR) begin
      e_done = 0; e_err = 1; e_code = 3; e_frames = MAXR + 1;
    end else begin
      e_done = 1; e_err = 0; e_code = 0; e_frames = n_fe + 1;
    end
  endtask

  typedef struct {
    logic [7:0] cmd;
    bit         nack;
    int         n_fe;
    bit         noise;
    int         e_done;
    int         e_err;
    int         e_code;
    int         e_frames;
  } vec_t;

  task automatic check_txn(input string tag, input logic [7:0] c, input bit nack, input int n_fe,
                           input bit noise, input int e_done, input int e_err, input int e_code,
                           input int e_frames);
    int d0, r0, b0, frames;
    d0 = done_cnt;
    r0 = err_cnt;
    b0 = busy_at_done;
    run_cmd(c, nack, n_fe, noise, frames);
    chk({tag, "_frames"}, 32'(frames), 32'(e_frames));
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'(e_done));
    chk({tag, "_err_pulses"}, 32'(err_cnt - r0), 32'(e_err));
    chk({tag, "_err_code"}, 32'(err_code), 32'(e_code));
    if (e_err != 0) chk({tag, "_code_at_pulse"}, 32'(last_code), 32'(e_code));
    chk({tag, "_busy_at_done"}, 32'(busy_at_done - b0), 0);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    chk({tag, "_lines_released"}, 32'({clk_oe, dat_oe}), 0);
    if (busy) begin
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
    end
  endtask

  vec_t tbl[5];

  initial begin
    int e_done, e_err, e_code, e_frames, r0, n;
    bit ok;
    logic [7:0] rc;
    bit rn, rz;
    int rf;

    tbl[0] = '{8'hED, 1'b0, 0, 1'b0, 1, 0, 0, 1};
    tbl[1] = '{8'hF4, 1'b0, 1, 1'b0, 1, 0, 0, 2};
    tbl[2] = '{8'hFF, 1'b0, 3, 1'b0, 0, 1, 3, 3};
    tbl[3] = '{8'hED, 1'b1, 0, 1'b0, 0, 1, 2, 1};
    tbl[4] = '{8'h00, 1'b0, 2, 1'b1, 1, 0, 0, 3};

    tick(3);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_outputs", 32'({clk_oe, dat_oe, rx_hold, busy, done, err}), 0);
    chk("rst_err_code", 32'(err_code), 0);
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 5; i++)
      check_txn($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].nack, tbl[i].n_fe, tbl[i].noise,
                tbl[i].e_done, tbl[i].e_err, tbl[i].e_code, tbl[i].e_frames);

    for (int i = 0; i < 6; i++) begin
      rc = 8'($urandom);
      rn = ($urandom_range(0, 4) == 0);
      rf = $urandom_range(0, 3);
      rz = 1'($urandom_range(0, 1));
      model(rn, rf, e_done, e_err, e_code, e_frames);
      check_txn($sformatf("rnd%0d", i), rc, rn, rf, rz, e_done, e_err, e_code, e_frames);
    end

    // Device stops clocking after edge 4: timeout counted from the RTS cycle.
    r0 = err_cnt;
    start_cmd(8'h12);
    wait_frame_start(ok);
    for (int e = 0; e < 4; e++) begin
      tick(2);
      pulse_edge();
    end
    n = 0;
    while (err_cnt == r0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_err_pulses", 32'(err_cnt - r0), 1);
    chk("tmo_cycles_from_rts", 32'(err_cyc - rts_cyc), 32'(TMO));
    chk("tmo_code", 32'(last_code), 32'(ERR_TIMEOUT));
    chk("tmo_lines_released", 32'({clk_oe, dat_oe, busy}), 0);
    tick(2);
    chk("tmo_code_held", 32'(err_code), 32'(ERR_TIMEOUT));

    // Asynchronous reset between clock edges in the middle of SHIFT.
    start_cmd(8'hA5);
    wait_frame_start(ok);
    for (int e = 0; e < 3; e++) begin
      tick(2);
      pulse_edge();
    end
    tick(1);
    chk("pre_reset_busy", 32'(busy), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_lines", 32'({clk_oe, dat_oe, rx_hold}), 0);
    chk("async_rst_status", 32'({busy, done, err, err_code}), 0);
    tick(2);
    rst_n = 1'b1;
    check_txn("after_reset", 8'h3C, 1'b0, 0, 1'b0, 1, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_ctrl.md
Name: ps2_cmd_ctrl

Overview:
- Host-to-device command sequencer for the PS/2 keyboard path; sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset).
- Sequence: inhibit clock, request-to-send, shift the frame out on device clock edges, check line ACK, wait for the 0xFA/0xFE response byte.
- Sits beside kb_sampling_en and recv: consumes their edge strobe and received bytes, drives the open-drain clock/data pull-downs, and holds off recv while transmitting.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles the PS/2 clock is held low before RTS (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: max clk cycles from RTS to response byte (20 ms at 50 MHz).
- MAX_RETRY, 2: resend attempts allowed after 0xFE.

Ports:
- clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_edge_en  in  1  one-cycle strobe per PS/2 clock falling edge (from kb_sampling_en).
- i_ps2_dat  in  1  synchronised PS/2 data line.
- i_byte_en  in  1  received-byte strobe from recv.
- i_byte  in  8  received byte from recv.
- i_cmd_valid  in  1  command request.
- i_cmd  in  8  command byte.
- o_cmd_ready  out  1  high only in IDLE.
- o_ps2_clk_oe  out  1  1 = pull PS/2 clock low.
- o_ps2_dat_oe  out  1  1 = pull PS/2 data low.
- o_rx_hold  out  1  high = recv must be held cleared; integrator ORs it into recv's clear.
- o_busy  out  1  high in any state except IDLE.
- o_done  out  1  one-cycle pulse: command acknowledged with 0xFA.
- o_err  out  1  one-cycle pulse: command failed.
- o_err_code  out  2  00 none, 01 timeout, 10 no line ACK, 11 retries exhausted; held until next accept.

Behaviour:
- Reset (i_rst_n=0, async):
  - State IDLE; both oe signals 0 (lines released).
  - o_rx_hold, o_busy, o_done, o_err and o_err_code all 0.
  - Counters and retry count cleared.
  - Reset mid-frame releases the lines immediately.
- IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid: latch i_cmd, compute parity = ~^cmd, clear retry count and o_err_code, go INHIBIT next cycle.
  - i_cmd_valid in any other state is ignored; it is not queued.
- INHIBIT:
  - clk_oe=1, dat_oe=0, o_rx_hold=1.
  - After INHIBIT_CYCLES cycles, go RTS.
- RTS:
  - dat_oe=1 (start bit 0) for one cycle with clk_oe=1, then clk_oe=0.
  - Start the timeout counter and bit index=0, then go SHIFT.
- SHIFT, advancing on each i_edge_en:
  - Edges 1..8 drive data bit index-1, LSB first; dat_oe = ~bit.
  - Edge 9 drives parity.
  - Edge 10 drives stop: dat_oe=0.
  - Then go ACK.
- ACK:
  - On the next i_edge_en, sample i_ps2_dat.
  - If i_ps2_dat=0, deassert o_rx_hold and go RESP.
  - If i_ps2_dat=1, raise err code 10 and go IDLE.
- RESP:
  - i_byte_en with 0xFA: o_done pulse, go IDLE.
  - 0xFE with retry count < MAX_RETRY: increment retry count, go INHIBIT.
  - 0xFE otherwise: err code 11, go IDLE.
  - Any other byte is ignored.
- Timeout:
  - Counter runs in SHIFT, ACK and RESP; it is restarted on each retry's RTS.
  - Reaching TIMEOUT_CYCLES in any of these states: err code 11 does not apply; raise code 01, release the lines, go IDLE.
  - Timeout takes priority over a same-cycle edge or byte.
- Every error pulses o_err for one cycle together with the new o_err_code.
- i_byte_en outside RESP is ignored.
- o_ledr-style debug is not provided here.

Decomposition:
- Package ps2_pkg:
  - State encoding (IDLE, INHIBIT, RTS, SHIFT, ACK, RESP).
  - Constants PS2_ACK=8'hFA, PS2_RESEND=8'hFE.
  - Error codes ERR_NONE, ERR_TIMEOUT, ERR_NOACK, ERR_RETRY.
- Sub-module ps2_tx_shift:
  - 11-bit frame serializer: load cmd + parity, advance on strobe, output dat_oe and a last-bit flag.
  - The FSM and timers stay in ps2_cmd_ctrl.

Test Plan:
- Happy path: cmd 0xED, device model clocks 11 edges, ACK low, returns 0xFA.
  - Data bits observed 1,0,1,1,0,1,1,1, parity 1, stop released.
  - o_done pulses once; o_busy falls the same cycle.
- Resend: device returns 0xFE, then 0xFA on the second frame.
  - Two full INHIBIT/frame sequences occur; o_done=1; o_err never pulses.
- Retries exhausted: device returns 0xFE three times with MAX_RETRY=2.
  - o_err pulses with code 11 after the third 0xFE; lines are released.
- No line ACK: i_ps2_dat=1 at edge 11.
  - o_err pulses with code 10; o_rx_hold=0; state IDLE.
- Timeout with TIMEOUT_CYCLES=200: device stops clocking after edge 4.
  - o_err pulses at cycle 200 after RTS with code 01; clk_oe=0, dat_oe=0.
- Async reset mid-SHIFT with i_rst_n low between clock edges.
  - All outputs 0 immediately; a new i_cmd_valid after release is accepted.
